// File: rtl/fde_seq.sv
// Fetch/decode/execute(/writeback) instruction-cycle sequencer with fetch stall,
// variable-length execute, flush, halt and a retired-instruction counter.
// All outputs are registered from the next-state decode; no input-to-output paths.
module fde_seq #(
  parameter int          WIDTH      = 8,
  parameter int          EXEC_CNT_W = 3,
  parameter int unsigned USE_WB     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  mem_ready,
  input  logic [EXEC_CNT_W-1:0] exec_cycles,
  input  logic                  flush,
  input  logic                  halt,
  output logic                  fetch,
  output logic                  decode,
  output logic                  execute,
  output logic                  writeback,
  output logic [2:0]            phase,
  output logic                  busy,
  output logic                  instr_done,
  output logic                  halted,
  output logic [WIDTH-1:0]      instr_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALTED    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [EXEC_CNT_W-1:0] exec_left_q, exec_left_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  halt_pending_q, halt_pending_d;
  logic                  retire;
  logic                  in_phase;

  logic fetch_q, decode_q, execute_q, writeback_q;
  logic busy_q, halted_q, done_q;
  logic [2:0] phase_q;

  // Phase states are the ones where an instruction is in flight.
  assign in_phase = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXECUTE) || (state_q == S_WRITEBACK);

  // Next-state decode: flush beats enable gating, which beats the normal walk.
  always_comb begin
    state_d        = state_q;
    exec_left_d    = exec_left_q;
    count_d        = count_q;
    retire         = 1'b0;
    // A halt seen at any point of an instruction is remembered until reset.
    halt_pending_d = halt_pending_q | (halt & in_phase);

    unique case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_HALTED;
        end else if (enable) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // A flush here simply restarts the fetch, so the data beat is dropped.
        if (!flush && enable && mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (flush) begin
          state_d     = S_FETCH;
          exec_left_d = '0;
        end else if (enable) begin
          state_d     = S_EXECUTE;
          // A zero-length execute still occupies one cycle.
          exec_left_d = (exec_cycles == '0) ? EXEC_CNT_W'(1) : exec_cycles;
        end
      end
      S_EXECUTE: begin
        if (flush) begin
          state_d     = S_FETCH;
          exec_left_d = '0;
        end else if (enable) begin
          if (exec_left_q <= EXEC_CNT_W'(1)) begin
            exec_left_d = '0;
            if (USE_WB != 0) begin
              state_d = S_WRITEBACK;
            end else begin
              retire = 1'b1;
            end
          end else begin
            exec_left_d = exec_left_q - EXEC_CNT_W'(1);
          end
        end
      end
      S_WRITEBACK: begin
        if (flush) begin
          state_d     = S_FETCH;
          exec_left_d = '0;
        end else if (enable) begin
          retire = 1'b1;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d     = S_IDLE;
        exec_left_d = '0;
      end
    endcase

    // Instruction boundary: count it and either halt or start the next fetch.
    if (retire) begin
      count_d = count_q + WIDTH'(1);
      state_d = (halt_pending_q || halt) ? S_HALTED : S_FETCH;
    end
  end

  // State, counters and registered phase outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      exec_left_q    <= '0;
      count_q        <= '0;
      halt_pending_q <= 1'b0;
      fetch_q        <= 1'b0;
      decode_q       <= 1'b0;
      execute_q      <= 1'b0;
      writeback_q    <= 1'b0;
      busy_q         <= 1'b0;
      halted_q       <= 1'b0;
      done_q         <= 1'b0;
      phase_q        <= 3'd0;
    end else begin
      state_q        <= state_d;
      exec_left_q    <= exec_left_d;
      count_q        <= count_d;
      halt_pending_q <= halt_pending_d;
      fetch_q        <= (state_d == S_FETCH);
      decode_q       <= (state_d == S_DECODE);
      execute_q      <= (state_d == S_EXECUTE);
      writeback_q    <= (state_d == S_WRITEBACK);
      busy_q         <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                        (state_d == S_EXECUTE) || (state_d == S_WRITEBACK);
      halted_q       <= (state_d == S_HALTED);
      done_q         <= retire;
      phase_q        <= state_d;
    end
  end

  assign fetch       = fetch_q;
  assign decode      = decode_q;
  assign execute     = execute_q;
  assign writeback   = (USE_WB != 0) ? writeback_q : 1'b0;
  assign phase       = phase_q;
  assign busy        = busy_q;
  assign instr_done  = done_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

endmodule

// File: doc/fde_seq.md
Name: fde_seq

Overview:
- Parametrised fetch/decode/execute(/writeback) instruction-cycle sequencer; next generation of the 8-bit FDE phase generator.
- Adds:
  - fetch stall on memory handshake
  - variable-length execute supplied at decode
  - optional writeback phase
  - flush, halt, and a retired-instruction counter
- Sits between the program counter/memory interface and the ALU/register-file control, which key off its one-hot phase outputs.

Parameters:
- WIDTH, 8, width of instr_count (wraps modulo 2^WIDTH).
- EXEC_CNT_W, 3, width of exec_cycles input.
- USE_WB, 1, 1 = include WRITEBACK phase; 0 = omit it (writeback tied 0).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  advance permission; 0 freezes state and counters.
- mem_ready  input  1  fetch data valid; FETCH completes only when 1.
- exec_cycles  input  EXEC_CNT_W  execute length, sampled in DECODE.
- flush  input  1  abort current instruction, restart at FETCH.
- halt  input  1  stop at next instruction boundary.
- fetch  output  1  high in FETCH.
- decode  output  1  high in DECODE.
- execute  output  1  high in EXECUTE.
- writeback  output  1  high in WRITEBACK.
- phase  output  3  state code: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALTED=5.
- busy  output  1  high in FETCH, DECODE, EXECUTE, WRITEBACK.
- instr_done  output  1  one-cycle pulse per retired instruction.
- halted  output  1  high in HALTED.
- instr_count  output  WIDTH  retired-instruction count.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; all outputs 0; instr_count=0; exec_left=0; halt_pending=0.
- All outputs are registered/derived from state registers; no combinational path from inputs to outputs.
- In any phase state exactly one of fetch/decode/execute/writeback is high; none is high in IDLE or HALTED.
- Transition priority per clock edge: flush > enable gating > normal transition.
- IDLE:
  - halt=1 -> HALTED.
  - else enable=1 -> FETCH.
  - else stay.
- FETCH:
  - enable=1 and mem_ready=1 -> DECODE.
  - else stay (stall, unbounded).
- DECODE:
  - enable=1 -> EXECUTE; exec_left <= exec_cycles.
  - exec_cycles=0 is treated as 1.
- EXECUTE:
  - Occupies exactly max(exec_cycles,1) enabled cycles; exec_left decrements on each enabled cycle.
  - On the last enabled cycle -> WRITEBACK if USE_WB=1, else retire.
- WRITEBACK: one enabled cycle, then retire.
- Retire:
  - instr_count <= instr_count+1 (wraps all-ones -> 0).
  - instr_done=1 for exactly the next cycle.
  - Next state = HALTED if halt_pending or halt=1 this cycle, else FETCH.
- enable=0 in a phase state: state, exec_left and instr_count hold; instr_done is still a single-cycle pulse.
- halt_pending:
  - Set by halt=1 in any cycle while busy.
  - Cleared only by reset.
  - Never aborts a phase early.
- HALTED: absorbing; left only by reset. flush and enable are ignored.
- flush=1 in DECODE/EXECUTE/WRITEBACK:
  - -> FETCH next edge regardless of enable.
  - No retire, no instr_done, no count.
  - exec_left cleared; halt_pending retained.
- flush=1 in FETCH: stays FETCH (fetch restarts); mem_ready ignored that cycle.
- flush=1 in IDLE: ignored.
- flush coincident with retire cycle: flush wins; instruction not counted.
- Minimum instruction latency (enable=1, mem_ready=1, exec_cycles<=1): 3 cycles with USE_WB=0, 4 with USE_WB=1.
- Reset mid-instruction: immediate return to IDLE with all outputs 0.

Test Plan:
- Reset, enable=1, mem_ready=1, exec_cycles=1, USE_WB=1 -> phase sequence 0,1,2,3,4,1...; instr_done pulses every 4 cycles; instr_count=3 after 12 cycles from first FETCH.
- mem_ready held 0 for 5 cycles in FETCH, exec_cycles=4 -> fetch high 6 cycles; execute high exactly 4 consecutive cycles; one instr_done.
- enable dropped for 3 cycles mid-EXECUTE (exec_cycles=3) -> phase frozen at 3; execute asserted 3 enabled cycles total; instr_count unchanged while frozen.
- flush pulsed in EXECUTE of 2nd instruction -> next cycle phase=1; no instr_done; instr_count stays 1; flush in same cycle as WRITEBACK -> instr_count not incremented.
- halt pulsed one cycle during DECODE -> instruction completes, instr_done=1, then phase=5, halted=1, busy=0; later enable/flush toggles -> remains 5 until rst_n=0.
- WIDTH=2, USE_WB=0: run 5 instructions -> instr_count 1,2,3,0,1; writeback never high; rst_n asserted mid-DECODE -> all outputs 0 immediately (asynchronous).
